// File: rtl/jtframe_debug_sched.sv
// jtframe_debug_sched: round-robin scheduler feeding the debug_view overlay, relatched at vblank start.
// Defining JTFRAME_DEBUG_SCHED_FREEZE_EN adds a freeze input that pauses auto-advance and relatch.
module jtframe_debug_sched #(
    parameter int NSRC = 4,
    parameter int HOLD = 60,
    parameter int IDXW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lvbl,
    input  logic [8*NSRC-1:0] src_data,
    input  logic [NSRC-1:0]   src_en,
    input  logic              next,
    input  logic              auto_en,
`ifdef JTFRAME_DEBUG_SCHED_FREEZE_EN
    input  logic              freeze,
`endif
    output logic [7:0]        debug_view,
    output logic [IDXW-1:0]   src_sel,
    output logic              src_valid
);
    localparam int NP = 1 << IDXW;

    typedef enum logic [1:0] {IDLE, SEARCH, SHOW, ADVANCE} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] sel_q, sel_d, miss_q, miss_d, sel_inc;
    logic [7:0]      view_q, view_d, cnt_q, cnt_d, cur_dat;
    logic            valid_q, valid_d, lvbl_l_q, next_l_q;
    logic            frz, vb_edge, next_edge, cur_en, expire, advance;
    logic [NP-1:0]   en_x;
    logic [7:0]      dat_a [NP];

`ifdef JTFRAME_DEBUG_SCHED_FREEZE_EN
    assign frz = freeze;
`else
    assign frz = 1'b0;
`endif

    // Pad sources to the full index range so any src_sel value addresses a defined entry
    always_comb begin
        en_x = '0;
        en_x[NSRC-1:0] = src_en;
        dat_a = '{default: '0};
        for (int i = 0; i < NSRC; i++) dat_a[i] = src_data[8*i +: 8];
    end

    assign cur_en    = en_x[sel_q];
    assign cur_dat   = dat_a[sel_q];
    assign vb_edge   = lvbl_l_q & ~lvbl;
    assign next_edge = next & ~next_l_q;
    assign sel_inc   = sel_q == IDXW'(NSRC-1) ? '0 : sel_q + 1'b1;
    assign expire    = auto_en & vb_edge & ~frz & (cnt_q == 8'(HOLD-1));
    assign advance   = next_edge | expire | ~cur_en;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        miss_d  = miss_q;
        view_d  = view_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (|src_en) begin
                    state_d = SEARCH;
                    miss_d  = '0;
                end
            end
            SEARCH: begin
                if (cur_en) begin
                    state_d = SHOW;
                    view_d  = cur_dat;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    sel_d  = sel_inc;
                    miss_d = miss_q + 1'b1;
                    if (miss_q == IDXW'(NSRC-1)) begin
                        state_d = IDLE;
                        view_d  = '0;
                    end
                end
            end
            SHOW: begin
                if (vb_edge & ~frz) begin
                    view_d = cur_dat;
                    cnt_d  = cnt_q == 8'(HOLD-1) ? '0 : cnt_q + 8'd1;
                end
                if (advance) begin
                    state_d = ADVANCE;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = SEARCH;
                sel_d   = sel_inc;
                miss_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            miss_q   <= '0;
            view_q   <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            lvbl_l_q <= 1'b0;
            next_l_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            miss_q   <= miss_d;
            view_q   <= view_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            lvbl_l_q <= lvbl;
            next_l_q <= next;
        end
    end

    assign debug_view = view_q;
    assign src_sel    = sel_q;
    assign src_valid  = valid_q;
endmodule

// File: tb/tb_jtframe_debug_sched.sv
// tb_jtframe_debug_sched: directed scoreboard bench; a HOLD=2 and a HOLD=1 instance share one stimulus.
module tb_jtframe_debug_sched;
    logic        clk = 0, rst_n = 0, lvbl = 1, next = 0, auto_en = 0, freeze = 0;
    logic [31:0] src_data = 32'hD4C3B2A1;
    logic [3:0]  src_en = 4'b1111;
    logic [7:0]  dv, dv1;
    logic [2:0]  ss, ss1;
    logic        sv, sv1;
    int          n_cmp = 0, n_bad = 0;

    typedef struct packed {logic cs; logic v; logic [2:0] s; logic [7:0] d;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    jtframe_debug_sched #(.NSRC(4), .HOLD(2), .IDXW(3)) dut (
        .clk(clk), .rst_n(rst_n), .lvbl(lvbl), .src_data(src_data), .src_en(src_en),
        .next(next), .auto_en(auto_en),
`ifdef JTFRAME_DEBUG_SCHED_FREEZE_EN
        .freeze(freeze),
`endif
        .debug_view(dv), .src_sel(ss), .src_valid(sv));

    jtframe_debug_sched #(.NSRC(4), .HOLD(1), .IDXW(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .lvbl(lvbl), .src_data(src_data), .src_en(src_en),
        .next(next), .auto_en(auto_en),
`ifdef JTFRAME_DEBUG_SCHED_FREEZE_EN
        .freeze(freeze),
`endif
        .debug_view(dv1), .src_sel(ss1), .src_valid(sv1));

    function automatic logic [7:0] byte_of(input int k);
        return src_data[8*k +: 8];
    endfunction

    task automatic push(input logic v, input logic [2:0] s, input logic [7:0] d, input logic cs = 1'b1);
        sb.push_back('{cs: cs, v: v, s: s, d: d});
    endtask

    task automatic check(input string tag, input logic v, input logic [2:0] s, input logic [7:0] d);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL %s: no expected entry queued", tag);
            return;
        end
        e = sb.pop_front();
        assert ({v, e.cs ? s : 3'd0, d} === {e.v, e.cs ? e.s : 3'd0, e.d})
            else begin
                n_bad++;
                $error("FAIL %s: got valid=%b sel=%0d view=%h, expected valid=%b sel=%0d view=%h",
                       tag, v, s, d, e.v, e.s, e.d);
            end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vblank();
        lvbl = 0;
        tick(1);
        lvbl = 1;
        tick(1);
    endtask

    task automatic pulse(input int n);
        next = 1;
        tick(1);
        next = 0;
        tick(n);
    endtask

    initial begin
        tick(1);
        push(0, 0, 8'h00);
        check("reset", sv, ss, dv);
        rst_n = 1;
        tick(3);
        push(1, 0, 8'hA1);
        check("first_show", sv, ss, dv);

        // auto mode: new data for source 0 must not appear until a vblank edge
        src_data[7:0] = 8'h55;
        auto_en = 1;
        tick(3);
        push(1, 0, 8'hA1);
        check("no_tear", sv, ss, dv);
        for (int k = 0; k < 4; k++) begin
            vblank();
            push(1, 3'(k), byte_of(k));
            check("auto_mid", sv, ss, dv);
            vblank();
            tick(2);
            push(1, 3'((k + 1) % 4), byte_of((k + 1) % 4));
            check("auto_step", sv, ss, dv);
        end
        auto_en = 0;

        src_en = 4'b1001;
        pulse(0);
        push(0, 0, 8'h55);
        check("valid_drop", sv, ss, dv);
        tick(4);
        push(1, 3, 8'hD4);
        check("skip_to_3", sv, ss, dv);
        pulse(2);
        push(1, 0, 8'h55);
        check("wrap_to_0", sv, ss, dv);

        src_en = 4'b1111;
        pulse(2);
        push(1, 1, 8'hB2);
        check("show_1", sv, ss, dv);
        src_en = 4'b0100;
        tick(4);
        push(1, 2, 8'hC3);
        check("en_drop", sv, ss, dv);
        src_en = 4'b0000;
        tick(8);
        push(0, 0, 8'h00, 1'b0);
        check("to_idle", sv, ss, dv);

        // next edge coinciding with HOLD=1 expiry
        rst_n = 0;
        tick(1);
        rst_n = 1;
        src_en = 4'b1111;
        auto_en = 1;
        tick(3);
        next = 1;
        lvbl = 0;
        tick(1);
        next = 0;
        lvbl = 1;
        tick(2);
        push(1, 1, 8'hB2);
        check("coincide", sv1, ss1, dv1);
        n_cmp++;
        assert (dut1.cnt_q === 8'd0)
            else begin
                n_bad++;
                $error("FAIL coincide_cnt: got frame_cnt=%0d, expected 0", dut1.cnt_q);
            end
        tick(5);
        push(1, 1, 8'hB2);
        check("one_step", sv1, ss1, dv1);

`ifdef JTFRAME_DEBUG_SCHED_FREEZE_EN
        freeze = 1;
        src_data[15:8] = 8'h77;
        repeat (10) vblank();
        push(1, 1, 8'hB2);
        check("frozen", sv, ss, dv);
        pulse(2);
        push(1, 2, 8'hC3);
        check("frozen_next", sv, ss, dv);
        freeze = 0;
`endif

        auto_en = 0;
        src_en = 4'b0001;
        pulse(1);
        rst_n = 0;
        #1;
        push(0, 0, 8'h00);
        check("reset_in_search", sv, ss, dv);
        tick(1);
        rst_n = 1;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
